// File: rtl/cnn_job_host.sv
// cnn_job_host
// Host-side job sequencer for the CNN inference engine. It collects one
// NPIX-word frame into a local buffer, holds the buffer on the engine image
// port, and pulses engine reset (2 cycles) followed by enable (1 cycle). It
// then waits for the engine's done pulse or a timeout and returns the result
// over a valid/ready channel.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   s_valid/s_data/s_last/s_ready pixel stream in (raster order)
//   img_out[0:NPIX-1]             frame buffer to the engine, stable outside LOAD
//   eng_rst, eng_enable           per-job engine reset / start
//   eng_done, eng_value           engine completion pulse and result
//   m_valid/m_data/m_timeout/m_ready  result channel (m_data = 0 on timeout)
//   err_frame                     one-cycle pulse on a malformed frame
//   busy                          high in every state except LOAD
//
// state | meaning
// LOAD  | accepting pixel beats into the frame buffer
// ERST  | engine reset held for 2 cycles
// START | engine enable for 1 cycle, timeout counter cleared
// WAIT  | waiting for eng_done or timeout expiry
// RESP  | result presented until m_ready
module cnn_job_host #(
  parameter int DATA_W  = 32,
  parameter int NPIX    = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] img_out [0:NPIX-1],
  output logic              eng_rst,
  output logic              eng_enable,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_value,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_timeout,
  input  logic              m_ready,
  output logic              err_frame,
  output logic              busy
);

  localparam int PTR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {LOAD, ERST, START, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [1:0]        rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_timeout_q, m_timeout_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic              s_ready_q, busy_q, eng_rst_q, eng_en_q, m_valid_q;
  logic [DATA_W-1:0] img_q [0:NPIX-1];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rcnt_d      = rcnt_q;
    tcnt_d      = tcnt_q;
    m_data_d    = m_data_q;
    m_timeout_d = m_timeout_q;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      LOAD: begin
        if (s_valid) begin
          wr_en = 1'b1;
          if (ptr_q == PTR_W'(NPIX - 1) && s_last) begin
            ptr_d   = '0;
            rcnt_d  = '0;
            state_d = ERST;
          end else if (ptr_q == PTR_W'(NPIX - 1) || s_last) begin
            // Malformed frame: restart collection, keep stale words.
            err_d = 1'b1;
            ptr_d = '0;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end
      ERST: begin
        if (rcnt_q == 2'd1) state_d = START;
        else                rcnt_d  = rcnt_q + 2'd1;
      end
      START: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tcnt_d = tcnt_q + CNT_W'(1);
        // done takes priority over expiry on the same cycle
        if (eng_done) begin
          m_data_d    = eng_value;
          m_timeout_d = 1'b0;
          state_d     = RESP;
        end else if (tcnt_d == CNT_W'(TIMEOUT - 1)) begin
          m_data_d    = '0;
          m_timeout_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (m_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Status outputs are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      ptr_q       <= '0;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      m_data_q    <= '0;
      m_timeout_q <= 1'b0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b1;
      busy_q      <= 1'b0;
      eng_rst_q   <= 1'b0;
      eng_en_q    <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      m_data_q    <= m_data_d;
      m_timeout_q <= m_timeout_d;
      err_q       <= err_d;
      s_ready_q   <= (state_d == LOAD);
      busy_q      <= (state_d != LOAD);
      eng_rst_q   <= (state_d == ERST);
      eng_en_q    <= (state_d == START);
      m_valid_q   <= (state_d == RESP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPIX; i++) img_q[i] <= '0;
    end else if (wr_en) begin
      img_q[ptr_q] <= s_data;
    end
  end

  assign img_out    = img_q;
  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign eng_rst    = eng_rst_q;
  assign eng_enable = eng_en_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_timeout  = m_timeout_q;
  assign err_frame  = err_q;

endmodule

// File: tb/tb_cnn_job_host.sv
module tb_cnn_job_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] img_out [0:63];
  logic        eng_rst, eng_enable;
  logic        eng_done = 1'b0;
  logic [31:0] eng_value = '0;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_timeout;
  logic        m_ready = 1'b0;
  logic        err_frame, busy;

  int checks = 0;
  int failures = 0;

  cnn_job_host #(.DATA_W(32), .NPIX(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .img_out(img_out),
    .eng_rst(eng_rst), .eng_enable(eng_enable),
    .eng_done(eng_done), .eng_value(eng_value),
    .m_valid(m_valid), .m_data(m_data), .m_timeout(m_timeout), .m_ready(m_ready),
    .err_frame(err_frame), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drives nbeats beats starting at base; s_last on beat index last_at.
  // Returns at the falling edge just after the final beat was accepted.
  task automatic send_frame(input logic [31:0] base, input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = base + 32'(i);
      s_last  = (i == last_at);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({eng_rst, eng_enable, m_valid, m_timeout, err_frame} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {eng_rst, eng_enable, m_valid, m_timeout, err_frame}); end
    checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    checks++; if (img_out[0] !== 32'h0 || img_out[63] !== 32'h0) begin failures++; $display("FAIL reset_img got=%h/%h exp=0/0", img_out[0], img_out[63]); end
  endtask

  task automatic test_basic;
    int bad;
    send_frame(32'd1, 64, 63);
    checks++; if ({eng_rst, eng_enable, s_ready, busy} !== 4'b1001) begin failures++; $display("FAIL basic_c1 got=%b exp=1001", {eng_rst, eng_enable, s_ready, busy}); end
    @(negedge clk);
    checks++; if ({eng_rst, eng_enable} !== 2'b10) begin failures++; $display("FAIL basic_c2 got=%b exp=10", {eng_rst, eng_enable}); end
    @(negedge clk);
    checks++; if ({eng_rst, eng_enable} !== 2'b01) begin failures++; $display("FAIL basic_c3 got=%b exp=01", {eng_rst, eng_enable}); end
    bad = 0;
    for (int i = 0; i < 64; i++) if (img_out[i] !== 32'(i + 1)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_img got=%0d_bad_words exp=0", bad); end
    repeat (10) @(negedge clk);
    checks++; if ({eng_enable, m_valid} !== 2'b00) begin failures++; $display("FAIL basic_wait got=%b exp=00", {eng_enable, m_valid}); end
    eng_done = 1'b1; eng_value = 32'hA5;
    @(negedge clk);
    eng_done = 1'b0; eng_value = 32'h0;
    checks++; if ({m_valid, m_timeout} !== 2'b10) begin failures++; $display("FAIL basic_resp got=%b exp=10", {m_valid, m_timeout}); end
    checks++; if (m_data !== 32'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", m_data); end
    // m_ready held low: result must stay put and the stream stays closed
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== 32'hA5 || s_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_hold got=%0d_bad_cycles exp=0", bad); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if ({m_valid, s_ready, busy} !== 3'b010) begin failures++; $display("FAIL basic_handshake got=%b exp=010", {m_valid, s_ready, busy}); end
  endtask

  task automatic test_back_to_back;
    m_ready = 1'b1;
    send_frame(32'd100, 64, 63);
    repeat (3) @(negedge clk);
    eng_done = 1'b1; eng_value = 32'd7;
    @(negedge clk);
    eng_done = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd7) begin failures++; $display("FAIL b2b_job1 got=%b/%h exp=1/7", m_valid, m_data); end
    @(negedge clk);
    checks++; if ({m_valid, s_ready} !== 2'b01) begin failures++; $display("FAIL b2b_ret got=%b exp=01", {m_valid, s_ready}); end
    send_frame(32'd200, 64, 63);
    checks++; if (img_out[0] !== 32'd200 || img_out[63] !== 32'd263) begin failures++; $display("FAIL b2b_img got=%h/%h exp=c8/107", img_out[0], img_out[63]); end
    repeat (3) @(negedge clk);
    eng_done = 1'b1; eng_value = 32'd9;
    @(negedge clk);
    eng_done = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'd9 || m_timeout !== 1'b0) begin failures++; $display("FAIL b2b_job2 got=%b/%h/%b exp=1/9/0", m_valid, m_data, m_timeout); end
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_end got=%b exp=1", s_ready); end
  endtask

  task automatic test_err_early;
    int bad;
    send_frame(32'h50, 10, 9);
    checks++; if ({err_frame, s_ready, busy, eng_rst} !== 4'b1100) begin failures++; $display("FAIL early_pulse got=%b exp=1100", {err_frame, s_ready, busy, eng_rst}); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (err_frame !== 1'b0 || eng_rst !== 1'b0 || eng_enable !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL early_quiet got=%0d_bad_cycles exp=0", bad); end
    m_ready = 1'b1;
    send_frame(32'h1000, 64, 63);
    checks++; if (eng_rst !== 1'b1 || img_out[0] !== 32'h1000 || img_out[9] !== 32'h1009) begin failures++; $display("FAIL early_next got=%b/%h/%h exp=1/1000/1009", eng_rst, img_out[0], img_out[9]); end
    repeat (3) @(negedge clk);
    eng_done = 1'b1; eng_value = 32'h33;
    @(negedge clk);
    eng_done = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h33) begin failures++; $display("FAIL early_result got=%b/%h exp=1/33", m_valid, m_data); end
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_err_nolast;
    send_frame(32'h70, 64, -1);
    checks++; if ({err_frame, s_ready, busy, eng_rst} !== 4'b1100) begin failures++; $display("FAIL nolast_pulse got=%b exp=1100", {err_frame, s_ready, busy, eng_rst}); end
    checks++; if (img_out[63] !== 32'hAF) begin failures++; $display("FAIL nolast_img got=%h exp=af", img_out[63]); end
    @(negedge clk);
    checks++; if ({err_frame, eng_rst, eng_enable, busy} !== 4'b0000) begin failures++; $display("FAIL nolast_after got=%b exp=0000", {err_frame, eng_rst, eng_enable, busy}); end
  endtask

  task automatic test_timeout;
    send_frame(32'h300, 64, 63);
    @(negedge clk);
    @(negedge clk);
    checks++; if (eng_enable !== 1'b1) begin failures++; $display("FAIL to_enable got=%b exp=1", eng_enable); end
    repeat (15) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", m_valid); end
    @(negedge clk);
    checks++; if ({m_valid, m_timeout} !== 2'b11 || m_data !== 32'h0) begin failures++; $display("FAIL to_result got=%b/%h exp=11/0", {m_valid, m_timeout}, m_data); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if ({m_valid, s_ready} !== 2'b01) begin failures++; $display("FAIL to_handshake got=%b exp=01", {m_valid, s_ready}); end
  endtask

  task automatic test_tie;
    send_frame(32'h400, 64, 63);
    repeat (2) @(negedge clk);
    // done arrives on exactly the expiry edge
    repeat (15) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL tie_pre got=%b exp=0", m_valid); end
    eng_done = 1'b1; eng_value = 32'h5A;
    @(negedge clk);
    eng_done = 1'b0;
    checks++; if ({m_valid, m_timeout} !== 2'b10 || m_data !== 32'h5A) begin failures++; $display("FAIL tie_result got=%b/%h exp=10/5a", {m_valid, m_timeout}, m_data); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int bad;
    send_frame(32'h500, 64, 63);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({s_ready, busy, eng_rst, eng_enable, m_valid, err_frame} !== 6'b100000) begin failures++; $display("FAIL rstmid_out got=%b exp=100000", {s_ready, busy, eng_rst, eng_enable, m_valid, err_frame}); end
    checks++; if (img_out[0] !== 32'h0 || img_out[63] !== 32'h0) begin failures++; $display("FAIL rstmid_img got=%h/%h exp=0/0", img_out[0], img_out[63]); end
    @(negedge clk);
    rst = 1'b0;
    eng_done = 1'b1; eng_value = 32'h77;
    @(negedge clk);
    eng_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (m_valid !== 1'b0 || eng_enable !== 1'b0 || eng_rst !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_late_done got=%0d_bad_cycles exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_err_early();
    test_err_nolast();
    test_timeout();
    test_tie();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_job_host.md
# cnn_job_host

Host-side job sequencer that drives the CNN inference top (`cnn_top`) through its enable/done protocol. It collects a 64-pixel image over a valid/ready stream into a local frame buffer and holds the buffer stable on the engine's image port. It then issues a per-job engine reset and a one-cycle enable, waits for the engine's done pulse or a timeout, and returns the captured result over a valid/ready result channel. It sits between the system interconnect (DMA or test harness) and `cnn_top`, and allows back-to-back inferences without a global reset.

## Interface
- `DATA_W`, 32, pixel and result word width
- `NPIX`, 64, pixels per frame (8x8 image)
- `TIMEOUT`, 4096, maximum cycles WAIT remains in WAIT after `eng_enable`; must be ≥ 2

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s_valid`  in  1  pixel beat valid
- `s_data`  in  DATA_W  pixel word, raster order, index 0 first
- `s_last`  in  1  marks final beat of a frame
- `s_ready`  out  1  pixel beat accepted when `s_valid && s_ready`
- `img_out`  out  DATA_W x NPIX  frame buffer to the engine image port (unpacked array `[0:NPIX-1]`)
- `eng_rst`  out  1  engine reset, high for 2 cycles per job
- `eng_enable`  out  1  engine start, high for exactly 1 cycle per job
- `eng_done`  in  1  engine completion pulse
- `eng_value`  in  DATA_W  engine result, sampled on `eng_done`
- `m_valid`  out  1  result valid
- `m_data`  out  DATA_W  result word; 0 on timeout
- `m_timeout`  out  1  result flag: job timed out; qualified by `m_valid`
- `m_ready`  in  1  result accepted when `m_valid && m_ready`
- `err_frame`  out  1  one-cycle pulse on a malformed frame
- `busy`  out  1  high in every state except LOAD

## Operation
- States: LOAD, ERST, START, WAIT, RESP.
- LOAD: `s_ready`=1. Each accepted beat is written to `img_out[wr_ptr]` and increments `wr_ptr` (0..NPIX-1).
  - Accepted beat with `wr_ptr==NPIX-1` and `s_last`=1 → ERST; `wr_ptr` returns to 0.
  - Accepted beat with `s_last` inconsistent with position (early `s_last`, or 64th beat without `s_last`) → pulse `err_frame`, `wr_ptr`←0, stay in LOAD. Already-written buffer words are not cleared.
- ERST: `eng_rst`=1 for 2 cycles (2-bit counter), then → START.
- START: `eng_enable`=1 for 1 cycle; timeout counter cleared; → WAIT.
- WAIT: counter increments each cycle.
  - `eng_done`=1 → capture `eng_value` into `m_data`, `m_timeout`←0, → RESP.
  - Counter reaches TIMEOUT-1 without `eng_done` → `m_data`←0, `m_timeout`←1, → RESP.
  - `eng_done` on the same cycle as timeout expiry: done wins.
- RESP: `m_valid`=1 and `m_data`/`m_timeout` held until `m_ready`; then → LOAD. `eng_done` is ignored outside WAIT.
- `img_out` changes only in LOAD and is stable from ERST through RESP.
- Timeout counter width is `$clog2(TIMEOUT+1)`. No arithmetic on data; words pass through unmodified.

## Timing
- Reset (async assert, sync release) sets state=LOAD, `wr_ptr`=0, all `img_out` words=0, `s_ready`=1, `eng_rst`=0, `eng_enable`=0, `m_valid`=0, `m_data`=0, `m_timeout`=0, `err_frame`=0, `busy`=0.
- `s_ready` and `busy` are registered state decodes. In LOAD, a beat is accepted every cycle `s_valid` is high (full throughput).
- Frame-closing beat accepted at edge t: `eng_rst` high in cycles t+1 and t+2, `eng_enable` high in t+3, WAIT from t+4.
- `eng_done` sampled at edge d: `m_valid` high from d+1. Minimum round trip from last beat to `m_valid` is 5 cycles.
- `m_ready` is honoured from the first cycle of `m_valid`. The result handshake at edge r returns to LOAD with `s_ready`=1 at r+1. The next frame cannot be accepted before r+1.
- Reset mid-job drops the frame and any pending result; no `eng_enable` is issued after reset release until a full new frame arrives.

## Test plan
- Load pixels 1..64 with `s_last` on beat 64; engine model returns done after 20 cycles with value 0x0000_00A5 → `img_out[i]`=i+1; `eng_rst` high 2 cycles then `eng_enable` 1 cycle; `m_valid` with `m_data`=0xA5, `m_timeout`=0.
- Hold `m_ready` low 10 cycles → `m_data`/`m_valid` stable; `s_ready`=0 throughout; after handshake `s_ready`=1 next cycle. Two back-to-back jobs return values 7 then 9 in order.
- `s_last` on beat 10 → `err_frame` 1-cycle pulse, no `eng_rst`/`eng_enable`. The following correct 64-beat frame runs normally.
- 64th beat without `s_last` → `err_frame` pulse, state stays LOAD, `busy`=0.
- Engine never asserts done, TIMEOUT=16 → `m_valid` 16 cycles after `eng_enable` with `m_data`=0, `m_timeout`=1. With done and expiry on the same cycle → `m_timeout`=0 and value captured.
- Assert `rst` asynchronously during WAIT → all outputs at reset values immediately. A late `eng_done` after release produces no `m_valid`.
